// File: rtl/axi_stream_strip_header.sv
// Strips a 1..DATA_BYTE_WD byte header from each AXI-Stream packet and re-packs the payload MSB-first.
// Optional macro STRIP_ERR_EN enables the sticky err_len flag for packets shorter than their header.
module axi_stream_strip_header #(
   parameter int unsigned DATA_WD      = 32,
   parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
   parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
   output logic                    valid_header,
   output logic [DATA_WD-1:0]      data_header,
   output logic [DATA_BYTE_WD-1:0] keep_header,
   input  logic                    ready_header,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   output logic                    err_len
);

   localparam int unsigned CntWd = BYTE_CNT_WD + 1;
   localparam logic [CntWd-1:0] FullCnt = CntWd'(DATA_BYTE_WD);

   typedef enum logic [1:0] {StHead, StBody, StFlush} state_e;

   state_e                  state_q, state_d;
   logic [DATA_WD-1:0]      res_q, res_d;          // residue bytes, kept MSB-aligned
   logic [CntWd-1:0]        res_cnt_q, res_cnt_d;
   logic                    out_valid_q, out_valid_d;
   logic [DATA_WD-1:0]      out_data_q, out_data_d;
   logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
   logic                    out_last_q, out_last_d;
   logic                    hdr_valid_q, hdr_valid_d;
   logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
   logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;

   logic [DATA_WD-1:0]      data_m;
   logic [CntWd-1:0]        beat_cnt;
   logic [CntWd-1:0]        hdr_cnt;
   logic [CntWd-1:0]        total;
   logic                    out_free;
   logic                    hdr_free;
   logic                    ready_c;

   function automatic logic [DATA_BYTE_WD-1:0] top_keep(input logic [CntWd-1:0] n);
      top_keep = ~({DATA_BYTE_WD{1'b1}} >> n);
   endfunction

   // Zero the bytes outside keep so they never leak into outputs.
   always_comb begin
      data_m   = '0;
      beat_cnt = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         if (keep_in[i]) begin
            data_m[8*i +: 8] = data_in[8*i +: 8];
            beat_cnt         = beat_cnt + CntWd'(1);
         end
      end
   end

   assign hdr_cnt  = {1'b0, byte_strip_cnt} + CntWd'(1);
   assign total    = res_cnt_q + beat_cnt;
   assign out_free = !out_valid_q || ready_out;
   assign hdr_free = !hdr_valid_q || ready_header;

   always_comb begin
      state_d     = state_q;
      res_d       = res_q;
      res_cnt_d   = res_cnt_q;
      out_valid_d = out_valid_q && !ready_out;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      hdr_valid_d = hdr_valid_q && !ready_header;
      hdr_data_d  = hdr_data_q;
      hdr_keep_d  = hdr_keep_q;
      ready_c     = 1'b0;

      unique case (state_q)
         StHead: begin
            ready_c = hdr_free && out_free;
            if (valid_in && ready_c) begin
               hdr_valid_d = 1'b1;
               hdr_data_d  = data_m >> {FullCnt - hdr_cnt, 3'b000};
               hdr_keep_d  = ~({DATA_BYTE_WD{1'b1}} << hdr_cnt);
               res_d       = data_m << {hdr_cnt, 3'b000};
               res_cnt_d   = FullCnt - hdr_cnt;
               if (last_in) begin
                  res_d     = '0;
                  res_cnt_d = '0;
                  if (beat_cnt > hdr_cnt) begin
                     out_valid_d = 1'b1;
                     out_data_d  = data_m << {hdr_cnt, 3'b000};
                     out_keep_d  = keep_in << hdr_cnt;
                     out_last_d  = 1'b1;
                  end
               end else begin
                  state_d = StBody;
               end
            end
         end
         StBody: begin
            ready_c = out_free;
            if (valid_in && ready_c) begin
               out_valid_d = 1'b1;
               out_data_d  = res_q | (data_m >> {res_cnt_q, 3'b000});
               out_keep_d  = '1;
               out_last_d  = 1'b0;
               res_d       = data_m << {FullCnt - res_cnt_q, 3'b000};
               if (last_in) begin
                  if (total <= FullCnt) begin
                     out_keep_d = top_keep(total);
                     out_last_d = 1'b1;
                     res_d      = '0;
                     res_cnt_d  = '0;
                     state_d    = StHead;
                  end else begin
                     res_cnt_d = total - FullCnt;
                     state_d   = StFlush;
                  end
               end
            end
         end
         StFlush: begin
            if (out_free) begin
               out_valid_d = 1'b1;
               out_data_d  = res_q;
               out_keep_d  = top_keep(res_cnt_q);
               out_last_d  = 1'b1;
               res_d       = '0;
               res_cnt_d   = '0;
               state_d     = StHead;
            end
         end
         default: state_d = StHead;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StHead;
         res_q       <= '0;
         res_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         hdr_valid_q <= 1'b0;
         hdr_data_q  <= '0;
         hdr_keep_q  <= '0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         res_cnt_q   <= res_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         hdr_valid_q <= hdr_valid_d;
         hdr_data_q  <= hdr_data_d;
         hdr_keep_q  <= hdr_keep_d;
      end
   end

   assign ready_in     = ready_c;
   assign valid_out    = out_valid_q;
   assign data_out     = out_data_q;
   assign keep_out     = out_keep_q;
   assign last_out     = out_last_q;
   assign valid_header = hdr_valid_q;
   assign data_header  = hdr_data_q;
   assign keep_header  = hdr_keep_q;

`ifdef STRIP_ERR_EN
   logic err_q;

   // A one-beat packet shorter than its header latches the error until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (valid_in && ready_c && (state_q == StHead) && last_in &&
                   (beat_cnt < hdr_cnt)) begin
         err_q <= 1'b1;
      end
   end

   assign err_len = err_q;
`else
   assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header: directed packets, backpressure, random traffic against a
// byte-list model, error flag and mid-packet reset.
module tb_axi_stream_strip_header;

   typedef struct packed {logic [31:0] data; logic [3:0] keep; logic last;} beat_t;
   typedef struct packed {logic [31:0] data; logic [3:0] keep;} hdr_t;

   logic        clk;
   logic        rst_n;
   logic        valid_in;
   logic [31:0] data_in;
   logic [3:0]  keep_in;
   logic        last_in;
   logic        ready_in;
   logic [1:0]  byte_strip_cnt;
   logic        valid_header;
   logic [31:0] data_header;
   logic [3:0]  keep_header;
   logic        ready_header;
   logic        valid_out;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic        last_out;
   logic        ready_out;
   logic        err_len;

   int checks = 0;
   int errors = 0;

   beat_t      exp_pay[$];
   hdr_t       exp_hdr[$];
   logic [7:0] pkt[$];

   logic rand_ready = 1'b0;
   logic ro_force   = 1'b1;
   logic rh_force   = 1'b1;
   logic ro_rand    = 1'b1;
   logic rh_rand    = 1'b1;

   logic        prev_out_stall = 1'b0;
   logic        prev_hdr_stall = 1'b0;
   logic [31:0] pd, phd;
   logic [3:0]  pk, phk;
   logic        pl;

   axi_stream_strip_header dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_in       (valid_in),
      .data_in        (data_in),
      .keep_in        (keep_in),
      .last_in        (last_in),
      .ready_in       (ready_in),
      .byte_strip_cnt (byte_strip_cnt),
      .valid_header   (valid_header),
      .data_header    (data_header),
      .keep_header    (keep_header),
      .ready_header   (ready_header),
      .valid_out      (valid_out),
      .data_out       (data_out),
      .keep_out       (keep_out),
      .last_out       (last_out),
      .ready_out      (ready_out),
      .err_len        (err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      ro_rand <= ($urandom_range(0, 3) != 0);
      rh_rand <= ($urandom_range(0, 3) != 0);
   end

   assign ready_out    = rand_ready ? ro_rand : ro_force;
   assign ready_header = rand_ready ? rh_rand : rh_force;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_pay();
      beat_t e;
      chk("payload_expected", 32'(exp_pay.size() != 0), 32'd1);
      if (exp_pay.size() != 0) begin
         e = exp_pay.pop_front();
         chk("data_out", data_out, e.data);
         chk("keep_out", 32'(keep_out), 32'(e.keep));
         chk("last_out", 32'(last_out), 32'(e.last));
      end
   endtask

   task automatic check_hdr();
      hdr_t e;
      chk("header_expected", 32'(exp_hdr.size() != 0), 32'd1);
      if (exp_hdr.size() != 0) begin
         e = exp_hdr.pop_front();
         chk("data_header", data_header, e.data);
         chk("keep_header", 32'(keep_header), 32'(e.keep));
      end
   endtask

   task automatic check_holds();
      if (prev_out_stall) begin
         chk("hold_valid_out", 32'(valid_out), 32'd1);
         chk("hold_data_out", data_out, pd);
         chk("hold_keep_out", 32'(keep_out), 32'(pk));
         chk("hold_last_out", 32'(last_out), 32'(pl));
      end
      if (prev_hdr_stall) begin
         chk("hold_valid_header", 32'(valid_header), 32'd1);
         chk("hold_data_header", data_header, phd);
         chk("hold_keep_header", 32'(keep_header), 32'(phk));
      end
      if (valid_out && !ready_out) chk("ready_in_out_full", 32'(ready_in), 32'd0);
   endtask

   // Sampled on the falling edge, half a cycle away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_out_stall <= 1'b0;
         prev_hdr_stall <= 1'b0;
      end else begin
         check_holds();
         if (valid_out && ready_out) check_pay();
         if (valid_header && ready_header) check_hdr();
         prev_out_stall <= valid_out && !ready_out;
         prev_hdr_stall <= valid_header && !ready_header;
         pd  <= data_out;
         pk  <= keep_out;
         pl  <= last_out;
         phd <= data_header;
         phk <= keep_header;
      end
   end

   task automatic exp_h(input logic [31:0] d, input logic [3:0] k);
      hdr_t h;
      h.data = d;
      h.keep = k;
      exp_hdr.push_back(h);
   endtask

   task automatic exp_p(input logic [31:0] d, input logic [3:0] k, input logic l);
      beat_t b;
      b.data = d;
      b.keep = k;
      b.last = l;
      exp_pay.push_back(b);
   endtask

   task automatic add_word(input logic [31:0] w, input int nbytes);
      for (int i = 0; i < nbytes; i++) pkt.push_back(w[31-8*i -: 8]);
   endtask

   task automatic rand_pkt(input int len);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
   endtask

   // Header = first n bytes (absent ones read as 0); payload = the rest in 4-byte MSB-first chunks.
   task automatic model_packet(input int n);
      int    nb;
      hdr_t  h;
      beat_t b;
      nb     = pkt.size();
      h.data = '0;
      for (int i = 0; i < n; i++) begin
         if (i < nb) h.data = h.data | (32'(pkt[i]) << (8 * (n - 1 - i)));
      end
      h.keep = 4'((1 << n) - 1);
      exp_hdr.push_back(h);
      for (int s = n; s < nb; s += 4) begin
         b.data = '0;
         b.keep = '0;
         for (int p = 0; p < 4 && s + p < nb; p++) begin
            b.data[31-8*p -: 8] = pkt[s+p];
            b.keep[3-p]         = 1'b1;
         end
         b.last = (s + 4 >= nb);
         exp_pay.push_back(b);
      end
   endtask

   task automatic send_packet(input int n, input bit garbage);
      int nb;
      int beats;
      nb    = pkt.size();
      beats = (nb + 3) / 4;
      for (int bi = 0; bi < beats; bi++) begin
         logic [31:0] d;
         logic [3:0]  k;
         int          cyc;
         d = '0;
         k = '0;
         for (int p = 0; p < 4; p++) begin
            if (bi * 4 + p < nb) begin
               d[31-8*p -: 8] = pkt[bi*4+p];
               k[3-p]         = 1'b1;
            end else if (garbage) begin
               d[31-8*p -: 8] = 8'($urandom);
            end
         end
         valid_in       = 1'b1;
         data_in        = d;
         keep_in        = k;
         last_in        = (bi == beats - 1);
         byte_strip_cnt = (bi == 0) ? 2'(n - 1) : 2'($urandom);
         cyc = 0;
         @(negedge clk);
         while (!ready_in && cyc < 200) begin
            cyc++;
            @(negedge clk);
         end
         chk("send_accept_in_time", 32'(cyc < 200), 32'd1);
         @(posedge clk);
         #1;
      end
      valid_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic wait_drain();
      int c;
      c = 0;
      while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && c < 500) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk("drain", 32'(exp_pay.size() + exp_hdr.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_r;
      int len_r;
      rst_n          = 1'b0;
      valid_in       = 1'b0;
      data_in        = '0;
      keep_in        = '0;
      last_in        = 1'b0;
      byte_strip_cnt = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_valid_header", 32'(valid_header), 32'd0);
      chk("rst_last_out", 32'(last_out), 32'd0);
      chk("rst_err_len", 32'(err_len), 32'd0);
      chk("rst_data_out", data_out, 32'd0);
      chk("rst_keep_out", 32'(keep_out), 32'd0);
      chk("rst_data_header", data_header, 32'd0);
      chk("rst_keep_header", 32'(keep_header), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready_in", 32'(ready_in), 32'd1);
      @(posedge clk);
      #1;

      // N=2, three beats
      pkt.delete();
      add_word(32'h11223344, 4);
      add_word(32'h55667788, 4);
      add_word(32'h99AA0000, 2);
      exp_h(32'h00001122, 4'b0011);
      exp_p(32'h33445566, 4'b1111, 1'b0);
      exp_p(32'h778899AA, 4'b1111, 1'b1);
      send_packet(2, 0);
      wait_drain();

      // N=1 with a flush beat
      pkt.delete();
      add_word(32'hA1A2A3A4, 4);
      add_word(32'hB1B2B3B4, 3);
      exp_h(32'h000000A1, 4'b0001);
      exp_p(32'hA2A3A4B1, 4'b1111, 1'b0);
      exp_p(32'hB2B30000, 4'b1100, 1'b1);
      send_packet(1, 0);
      @(negedge clk);
      chk("flush_ready_in_low", 32'(ready_in), 32'd0);
      @(negedge clk);
      chk("after_flush_ready_in", 32'(ready_in), 32'd1);
      @(posedge clk);
      #1;
      wait_drain();

      // N=4 pass-through
      pkt.delete();
      add_word(32'hDEADBEEF, 4);
      add_word(32'h01020304, 1);
      exp_h(32'hDEADBEEF, 4'b1111);
      exp_p(32'h01000000, 4'b1000, 1'b1);
      send_packet(4, 0);
      wait_drain();

      // single-beat packet, N=2
      pkt.delete();
      add_word(32'hCAFEF00D, 4);
      exp_h(32'h0000CAFE, 4'b0011);
      exp_p(32'hF00D0000, 4'b1100, 1'b1);
      send_packet(2, 0);
      wait_drain();

      // packet shorter than its header
      chk("err_len_before", 32'(err_len), 32'd0);
      pkt.delete();
      pkt.push_back(8'hAB);
      exp_h(32'h00AB0000, 4'b0111);
      send_packet(3, 1);
      @(negedge clk);
`ifdef STRIP_ERR_EN
      chk("err_len_set", 32'(err_len), 32'd1);
`else
      chk("err_len_tied", 32'(err_len), 32'd0);
`endif
      @(posedge clk);
      #1;
      wait_drain();

      // payload backpressure for 5 cycles mid-packet
      rand_pkt(14);
      model_packet(2);
      fork
         send_packet(2, 1);
         begin
            repeat (2) @(posedge clk);
            #1;
            ro_force = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            ro_force = 1'b1;
         end
      join
      wait_drain();

      // header backpressure across a packet boundary
      rh_force = 1'b0;
      fork
         begin
            rand_pkt(8);
            model_packet(3);
            send_packet(3, 1);
            rand_pkt(6);
            model_packet(1);
            send_packet(1, 1);
         end
         begin
            int c;
            c = 0;
            @(negedge clk);
            while (!valid_header && c < 50) begin
               c++;
               @(negedge clk);
            end
            chk("header_appears", 32'(valid_header), 32'd1);
            @(negedge clk);
            @(negedge clk);
            chk("ready_in_header_pending", 32'(ready_in), 32'd0);
            chk("valid_header_pending", 32'(valid_header), 32'd1);
            @(posedge clk);
            #1;
            rh_force = 1'b1;
         end
      join
      wait_drain();

      // random packets with random readiness on both outputs
      rand_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         n_r   = $urandom_range(1, 4);
         len_r = $urandom_range(1, 13);
         rand_pkt(len_r);
         model_packet(n_r);
         send_packet(n_r, 1);
      end
      wait_drain();
      rand_ready = 1'b0;

      // reset in the middle of a packet
      ro_force       = 1'b0;
      rh_force       = 1'b0;
      valid_in       = 1'b1;
      data_in        = 32'h01020304;
      keep_in        = 4'hF;
      last_in        = 1'b0;
      byte_strip_cnt = 2'd1;
      @(posedge clk);
      #1;
      data_in = 32'h05060708;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      chk("pre_reset_valid_out", 32'(valid_out), 32'd1);
      chk("pre_reset_valid_header", 32'(valid_header), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid_out", 32'(valid_out), 32'd0);
      chk("mid_rst_valid_header", 32'(valid_header), 32'd0);
      chk("mid_rst_last_out", 32'(last_out), 32'd0);
      chk("mid_rst_err_len", 32'(err_len), 32'd0);
      chk("mid_rst_data_out", data_out, 32'd0);
      chk("mid_rst_keep_out", 32'(keep_out), 32'd0);
      chk("mid_rst_data_header", data_header, 32'd0);
      chk("mid_rst_keep_header", 32'(keep_header), 32'd0);
      exp_pay.delete();
      exp_hdr.delete();
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      ro_force = 1'b1;
      rh_force = 1'b1;
      @(posedge clk);
      #1;
      pkt.delete();
      add_word(32'h11223344, 4);
      add_word(32'h55000000, 1);
      exp_h(32'h00112233, 4'b0111);
      exp_p(32'h44550000, 4'b1100, 1'b1);
      send_packet(3, 0);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_stream_strip_header.md
# axi_stream_strip_header

Receive-side counterpart to `axi_stream_insert_header`. It takes an AXI-Stream packet whose first bytes are a header of 1..DATA_BYTE_WD bytes, removes that header, and presents it once per packet on a separate header port. The remaining payload is re-aligned to MSB-first full beats on the output stream. It sits after the link that carried header-inserted packets and feeds payload consumers.

## Interface
- DATA_WD, 32, data width in bits
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of strip count
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_in / data_in / keep_in / last_in  in  1/DATA_WD/DATA_BYTE_WD/1  input stream. Byte 0 is data[DATA_WD-1 -: 8] with keep bit MSB. keep is all-ones except on the last beat, where it is contiguous and MSB-aligned.
- ready_in  out  1  input accept
- byte_strip_cnt  in  BYTE_CNT_WD  header length minus 1 (N = cnt+1); sampled only on a packet's first accepted beat
- valid_header / data_header / keep_header  out  1/DATA_WD/DATA_BYTE_WD  header right-aligned; keep_header = (1<<N)-1
- ready_header  in  1  header accept
- valid_out / data_out / keep_out / last_out  out  1/DATA_WD/DATA_BYTE_WD/1  payload stream, MSB-aligned
- ready_out  in  1  payload accept
- err_len  out  1  sticky length error (only with STRIP_ERR_EN)

## Operation
- Transfer occurs on valid&&ready per port. The input uses a registered residue of R bytes (0..DATA_BYTE_WD-1) plus the FSM.
- **S_HEAD** (reset state): ready_in = !valid_header || ready_header, and the output slot is free.
  - On accept: latch N. The header is the top N bytes of the beat.
  - The residue is the low DATA_BYTE_WD-N bytes (R = DATA_BYTE_WD-N).
  - If last_in with k valid bytes: emit one last beat of k-N bytes if k>N; otherwise emit no payload. Stay in S_HEAD.
  - Else go to S_BODY.
- **S_BODY**: ready_in = output slot free (!valid_out || ready_out).
  - Each beat: out = {residue R bytes, top DATA_BYTE_WD-R bytes of beat}, keep all-ones. The new residue is the low R bytes.
  - On last_in, compute total T = R + k.
  - If T <= DATA_BYTE_WD: one beat, keep = top T bits, last_out=1, go to S_HEAD.
  - Else: full non-last beat, the residue becomes the leftover T-DATA_BYTE_WD bytes, go to S_FLUSH.
- **S_FLUSH**: ready_in=0. When the output slot is free, emit the residue with MSB-aligned keep, last_out=1, then go to S_HEAD.
- With N = DATA_BYTE_WD (R=0), the block is a pure pass-through of beats 2..end.
- Bytes outside keep_out and keep_header are driven 0.
- Header and payload ports are independent; a pending header blocks only the next packet's first beat.

## Timing
- Reset values: valid_out, valid_header, last_out, err_len = 0; all data/keep outputs = 0; FSM in S_HEAD, R=0.
- ready_in is combinational from registered state and ready_out/ready_header. After reset it is 1.
- Latency is one cycle from input accept to valid_out/valid_header. Flush adds one beat.
- Outputs are held stable while valid && !ready. valid never drops without a transfer.
- Full throughput (1 beat/cycle) is sustained with ready_out=1, except one ready_in=0 cycle per packet requiring flush.
- Simultaneous output drain and new load in the same cycle is supported with no bubble.
- Reset mid-packet discards the residue, any pending header and the output beat. Operation restarts in S_HEAD.

## Configuration
- STRIP_ERR_EN defined: err_len is set when a packet's first beat has last_in with k < N. It stays set until reset.
  - The header is still emitted with N bytes; missing bytes are 0. No payload is emitted.
- Not defined: err_len is tied 0 and the same data behaviour applies.

## Test plan
- N=2 (cnt=1), beats 0x11223344, 0x55667788, 0x99AA0000 keep 1100 last.
  - Expect header 0x00001122 keep 0011.
  - Expect payload 0x33445566 keep 1111, then 0x778899AA keep 1111 last.
- N=1 (cnt=0), beats 0xA1A2A3A4, 0xB1B2B3B4 keep 1110 last.
  - Expect header 0x000000A1 keep 0001.
  - Expect payload 0xA2A3A4B1 keep 1111, then flush 0xB2B30000 keep 1100 last; ready_in=0 for the flush cycle.
- N=4 (cnt=3), beats 0xDEADBEEF, 0x01020304 keep 1000 last.
  - Expect header 0xDEADBEEF keep 1111.
  - Expect payload 0x01000000 keep 1000 last.
- Single beat 0xCAFEF00D keep 1111 last, N=2.
  - Expect header 0x0000CAFE keep 0011.
  - Expect payload 0xF00D0000 keep 1100 last.
- Backpressure: ready_out=0 for 5 cycles mid-packet, and ready_header=0 for 3 cycles across a packet boundary.
  - Expect no lost or duplicated bytes.
  - Expect outputs stable while stalled.
  - Expect ready_in=0 until a slot frees.
- With STRIP_ERR_EN, single beat keep 1000 last, N=3.
  - Expect err_len=1 the next cycle.
  - Expect header 0x00XX0000 keep 0111, where 0xXX is the beat's top byte.
  - Expect no payload beat.
- Assert rst_n mid-packet and expect all outputs to return to 0.
